dmg_lcd_capture: RTL and testbench
==================================

DMG_LCD_CAPTURE -- requirements
Module: dmg_lcd_capture

Interface
REQ-001 Parameter H_PIXELS, default 160, visible pixels per line.
REQ-002 Parameter V_LINES, default 144, visible lines per frame.
REQ-003 clk  input  1  single clock for all logic, rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low (0 = reset).
REQ-005 lcd_pixel  input  1  pixel strobe; one pixel per high cycle.
REQ-006 lcd_color  input  2  pixel shade, valid when lcd_pixel=1.
REQ-007 lcd_hsync  input  1  line-end marker; rising edge significant.
REQ-008 lcd_vsync  input  1  frame-start marker; rising edge significant.
REQ-009 err_clr  input  1  synchronous clear of sticky error flags.
REQ-010 fb_we  output  1  framebuffer write enable, one cycle per stored pixel.
REQ-011 fb_addr  output  16  {write bank, 15-bit offset y*H_PIXELS+x}.
REQ-012 fb_data  output  2  shade to write.
REQ-013 fb_rd_bank  output  1  bank holding the last complete frame.
REQ-014 frame_done  output  1  one-cycle pulse on completed frame.
REQ-015 err  output  3  sticky flags: [0] line too long, [1] too many lines, [2] short frame.

Function
REQ-016 hsync/vsync edges SHALL be detected by comparing against a one-cycle-delayed registered copy; the edge is acted on in the cycle the input first reads 1.
REQ-017 States SHALL be WAIT_FRAME, CAPTURE.
REQ-018 WAIT_FRAME: lcd_pixel and hsync ignored; vsync rising edge -> CAPTURE with x=0, y=0, line_base=0.
REQ-019 CAPTURE, lcd_pixel=1, x<H_PIXELS, y<V_LINES: next cycle fb_we=1, fb_addr={wbank, line_base+x}, fb_data=lcd_color; x increments.
REQ-020 Write latency SHALL be exactly one clock from the lcd_pixel sample to fb_we.
REQ-021 Pixel with x>=H_PIXELS SHALL be dropped, set err[0]; x saturates at H_PIXELS.
REQ-022 Pixel with y>=V_LINES SHALL be dropped, set err[1].
REQ-023 hsync rising edge in CAPTURE: x=0, y increments (saturating at V_LINES), line_base += H_PIXELS (held when y saturates); short lines leave the unwritten locations untouched.
REQ-024 Pixel and hsync edge in same cycle: pixel SHALL be stored on the current line, then line advances.
REQ-025 vsync rising edge in CAPTURE with y==V_LINES: frame_done pulses next cycle, wbank toggles, fb_rd_bank takes old wbank, counters restart at x=0, y=0, line_base=0; state stays CAPTURE.
REQ-026 vsync rising edge in CAPTURE with y!=V_LINES: err[2] set, no frame_done, wbank and fb_rd_bank unchanged, counters restart.
REQ-027 Pixel coincident with a vsync edge SHALL be discarded.
REQ-028 fb_rd_bank SHALL always equal ~wbank; writes never target fb_rd_bank.
REQ-029 err bits SHALL stay set until err_clr=1; err_clr wins over a same-cycle set.
REQ-030 fb_addr offset SHALL never exceed H_PIXELS*V_LINES-1 (23039 default).

Reset
REQ-031 rst=0 SHALL immediately force state WAIT_FRAME, x=y=line_base=0, wbank=0, fb_rd_bank=1, fb_we=0, fb_addr=0, fb_data=0, frame_done=0, err=0, edge registers=0.
REQ-032 Reset mid-frame SHALL abandon the frame with no frame_done and no bank swap; capture resumes only after the next vsync rising edge.

Verification
REQ-033 Reset, vsync edge, 144 lines of 160 pixels with hsync after each, vsync edge -> 23040 writes, addresses 0..23039 bank 0, frame_done once, fb_rd_bank 1->0.
REQ-034 Line of 162 pixels -> 160 writes, last offset 159, err[0]=1; err_clr -> err=0.
REQ-035 Vsync edge after 100 lines -> err[2]=1, no frame_done, fb_rd_bank unchanged, next write offset 0.
REQ-036 Pixel (color 3) and hsync edge same cycle at x=5,y=0 -> write offset 5 data 3; next pixel writes offset 160.
REQ-037 Pixels before first vsync -> no fb_we; vsync held high several cycles -> single restart.
REQ-038 rst low at line 70 -> outputs at reset values that cycle, no frame_done, second complete frame after restart writes bank 0.

Source files
------------

// File: rtl/dmg_lcd_capture.sv
// Captures the Game Boy LCD pixel stream into a double-buffered framebuffer.
// One bank is written while the other holds the last complete frame.
module dmg_lcd_capture #(
  parameter int H_PIXELS = 160,
  parameter int V_LINES  = 144
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lcd_pixel,
  input  logic [1:0]  lcd_color,
  input  logic        lcd_hsync,
  input  logic        lcd_vsync,
  input  logic        err_clr,
  output logic        fb_we,
  output logic [15:0] fb_addr,
  output logic [1:0]  fb_data,
  output logic        fb_rd_bank,
  output logic        frame_done,
  output logic [2:0]  err
);

  localparam int XW = $clog2(H_PIXELS + 1);
  localparam int YW = $clog2(V_LINES + 1);
  localparam logic [XW-1:0] X_MAX     = XW'(H_PIXELS);
  localparam logic [YW-1:0] Y_MAX     = YW'(V_LINES);
  localparam logic [14:0]   LINE_STEP = 15'(H_PIXELS);

  typedef enum logic {
    WAIT_FRAME,
    CAPTURE
  } state_t;

  state_t      state, state_n;
  logic [XW-1:0] x, x_n;
  logic [YW-1:0] y, y_n;
  logic [14:0] line_base, base_n;
  logic        wbank, wbank_n;
  logic        hsync_d, vsync_d;
  logic        we_n, done_n;
  logic [15:0] addr_n;
  logic [1:0]  data_n;
  logic [2:0]  err_set, err_n;
  logic        hs_rise, vs_rise;

  assign hs_rise    = lcd_hsync & ~hsync_d;
  assign vs_rise    = lcd_vsync & ~vsync_d;
  assign fb_rd_bank = ~wbank;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= WAIT_FRAME;
    else      state <= state_n;
  end

  // A vsync edge always wins: it closes the frame and discards any coincident pixel.
  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    base_n  = line_base;
    wbank_n = wbank;
    we_n    = 1'b0;
    addr_n  = fb_addr;
    data_n  = fb_data;
    done_n  = 1'b0;
    err_set = 3'b000;
    case (state)
      WAIT_FRAME: begin
        if (vs_rise) begin
          state_n = CAPTURE;
          x_n     = '0;
          y_n     = '0;
          base_n  = '0;
        end
      end
      CAPTURE: begin
        if (vs_rise) begin
          if (y == Y_MAX) begin
            done_n  = 1'b1;
            wbank_n = ~wbank;
          end else begin
            err_set[2] = 1'b1;
          end
          x_n    = '0;
          y_n    = '0;
          base_n = '0;
        end else begin
          if (lcd_pixel) begin
            if (y >= Y_MAX) begin
              err_set[1] = 1'b1;
            end else if (x >= X_MAX) begin
              err_set[0] = 1'b1;
            end else begin
              we_n   = 1'b1;
              addr_n = {wbank, line_base + 15'(x)};
              data_n = lcd_color;
              x_n    = x + XW'(1);
            end
          end
          // Line advance follows the pixel so a coincident pixel lands on the old line.
          if (hs_rise) begin
            x_n = '0;
            if (y < Y_MAX) begin
              y_n    = y + YW'(1);
              base_n = line_base + LINE_STEP;
            end
          end
        end
      end
    endcase
    err_n = err_clr ? 3'b000 : (err | err_set);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x          <= '0;
      y          <= '0;
      line_base  <= '0;
      wbank      <= 1'b0;
      hsync_d    <= 1'b0;
      vsync_d    <= 1'b0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
      frame_done <= 1'b0;
      err        <= '0;
    end else begin
      x          <= x_n;
      y          <= y_n;
      line_base  <= base_n;
      wbank      <= wbank_n;
      hsync_d    <= lcd_hsync;
      vsync_d    <= lcd_vsync;
      fb_we      <= we_n;
      fb_addr    <= addr_n;
      fb_data    <= data_n;
      frame_done <= done_n;
      err        <= err_n;
    end
  end

endmodule

// File: tb/tb_dmg_lcd_capture.sv
// Directed testbench for dmg_lcd_capture with hand-computed expectations.
module tb_dmg_lcd_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lcd_pixel = 1'b0;
  logic [1:0]  lcd_color = 2'd0;
  logic        lcd_hsync = 1'b0;
  logic        lcd_vsync = 1'b0;
  logic        err_clr = 1'b0;
  logic        fb_we;
  logic [15:0] fb_addr;
  logic [1:0]  fb_data;
  logic        fb_rd_bank;
  logic        frame_done;
  logic [2:0]  err;

  int checks = 0;
  int errors = 0;

  int          wr_count = 0;
  int          done_count = 0;
  int          bank_viol = 0;
  int          seq_err = 0;
  logic [15:0] last_addr = '0;
  logic [1:0]  last_data = '0;
  logic        seq_en = 1'b0;
  int          seq_base = 0;

  always #5 clk = ~clk;

  dmg_lcd_capture #(.H_PIXELS(160), .V_LINES(144)) dut (
    .clk(clk),
    .rst(rst),
    .lcd_pixel(lcd_pixel),
    .lcd_color(lcd_color),
    .lcd_hsync(lcd_hsync),
    .lcd_vsync(lcd_vsync),
    .err_clr(err_clr),
    .fb_we(fb_we),
    .fb_addr(fb_addr),
    .fb_data(fb_data),
    .fb_rd_bank(fb_rd_bank),
    .frame_done(frame_done),
    .err(err)
  );

  // Write monitor: a full frame must produce offsets 0,1,2,... with shade = offset mod 4.
  always @(posedge clk) begin
    int e;
    #1;
    if (fb_we) begin
      if (seq_en) begin
        e = wr_count - seq_base;
        if (fb_addr[14:0] != 15'(e) || fb_data != e[1:0]) seq_err++;
      end
      wr_count++;
      last_addr = fb_addr;
      last_data = fb_data;
      if (fb_addr[15] == fb_rd_bank) bank_viol++;
    end
    if (frame_done) done_count++;
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_pixel(input logic [1:0] c);
    lcd_pixel = 1'b1;
    lcd_color = c;
    tick();
    lcd_pixel = 1'b0;
  endtask

  task automatic hsync_pulse();
    lcd_hsync = 1'b1;
    tick();
    lcd_hsync = 1'b0;
    tick();
  endtask

  task automatic vsync_pulse();
    lcd_vsync = 1'b1;
    tick();
    lcd_vsync = 1'b0;
    tick();
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic send_line(input int n);
    for (int i = 0; i < n; i++) send_pixel(2'(i));
    hsync_pulse();
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_we"},     32'(fb_we), 32'd0);
    check_output({tag, "_addr"},   32'(fb_addr), 32'd0);
    check_output({tag, "_data"},   32'(fb_data), 32'd0);
    check_output({tag, "_rdbank"}, 32'(fb_rd_bank), 32'd1);
    check_output({tag, "_done"},   32'(frame_done), 32'd0);
    check_output({tag, "_err"},    32'(err), 32'd0);
  endtask

  task automatic full_frame_check(input string tag);
    int b, s, d;
    vsync_pulse();
    b = wr_count;
    s = seq_err;
    d = done_count;
    seq_base = wr_count;
    seq_en = 1'b1;
    for (int l = 0; l < 144; l++) send_line(160);
    check_output({tag, "_rdbank_before"}, 32'(fb_rd_bank), 32'd1);
    vsync_pulse();
    seq_en = 1'b0;
    check_output({tag, "_writes"},    32'(wr_count - b), 32'd23040);
    check_output({tag, "_sequence"},  32'(seq_err - s), 32'd0);
    check_output({tag, "_last_addr"}, 32'(last_addr), 32'd23039);
    check_output({tag, "_done"},      32'(done_count - d), 32'd1);
    check_output({tag, "_rdbank"},    32'(fb_rd_bank), 32'd0);
    check_output({tag, "_err"},       32'(err), 32'd0);
  endtask

  initial begin
    int b, d;

    // Reset state
    #2 rst = 1'b0;
    #1 check_reset_outputs("reset");
    tick(2);
    rst = 1'b1;
    tick();

    // Pixels before the first vsync are ignored; a held vsync restarts only once
    b = wr_count;
    for (int i = 0; i < 5; i++) send_pixel(2'd3);
    hsync_pulse();
    check_output("pre_vsync_writes", 32'(wr_count - b), 32'd0);
    lcd_vsync = 1'b1;
    tick();
    send_pixel(2'd1);
    check_output("held_vsync_addr0", 32'(last_addr), 32'd0);
    check_output("held_vsync_data0", 32'(last_data), 32'd1);
    send_pixel(2'd2);
    check_output("held_vsync_addr1", 32'(last_addr), 32'd1);
    tick(2);
    lcd_vsync = 1'b0;
    tick();
    check_output("held_vsync_writes", 32'(wr_count - b), 32'd2);
    check_output("held_vsync_err", 32'(err), 32'd0);

    // Complete frame into bank 0
    apply_reset();
    full_frame_check("frame1");

    // Over-long line: 162 pixels give 160 writes into bank 1
    b = wr_count;
    send_line(162);
    check_output("long_line_writes", 32'(wr_count - b), 32'd160);
    check_output("long_line_last_addr", 32'(last_addr), 32'h809F);
    check_output("long_line_last_data", 32'(last_data), 32'd3);
    check_output("long_line_err", 32'(err), 32'd1);
    clear_errors();
    check_output("err_cleared", 32'(err), 32'd0);

    // Short frame, then err_clr beating a coincident short-frame set
    d = done_count;
    vsync_pulse();
    check_output("short_frame_err", 32'(err), 32'd4);
    check_output("short_frame_done", 32'(done_count - d), 32'd0);
    check_output("short_frame_rdbank", 32'(fb_rd_bank), 32'd0);
    lcd_vsync = 1'b1;
    err_clr = 1'b1;
    tick();
    lcd_vsync = 1'b0;
    err_clr = 1'b0;
    tick();
    check_output("err_clr_wins", 32'(err), 32'd0);

    // Pixel coincident with hsync stays on the current line
    for (int i = 0; i < 5; i++) send_pixel(2'd0);
    lcd_pixel = 1'b1;
    lcd_color = 2'd3;
    lcd_hsync = 1'b1;
    tick();
    lcd_pixel = 1'b0;
    lcd_hsync = 1'b0;
    check_output("same_cycle_addr", 32'(last_addr), 32'h8005);
    check_output("same_cycle_data", 32'(last_data), 32'd3);
    send_pixel(2'd1);
    check_output("next_line_addr", 32'(last_addr), 32'h80A0);

    // Vsync after 100 lines is a short frame
    vsync_pulse();
    clear_errors();
    d = done_count;
    for (int l = 0; l < 100; l++) hsync_pulse();
    vsync_pulse();
    check_output("100_lines_err", 32'(err), 32'd4);
    check_output("100_lines_done", 32'(done_count - d), 32'd0);
    check_output("100_lines_rdbank", 32'(fb_rd_bank), 32'd0);
    send_pixel(2'd2);
    check_output("100_lines_next_addr", 32'(last_addr), 32'h8000);

    // Too many lines: y saturates, pixels dropped, yet vsync completes the frame
    clear_errors();
    for (int l = 0; l < 150; l++) hsync_pulse();
    b = wr_count;
    send_pixel(2'd1);
    check_output("extra_line_writes", 32'(wr_count - b), 32'd0);
    check_output("extra_line_err", 32'(err), 32'd2);
    d = done_count;
    vsync_pulse();
    check_output("saturated_done", 32'(done_count - d), 32'd1);
    check_output("saturated_rdbank", 32'(fb_rd_bank), 32'd1);

    // Reset at line 70 abandons the frame
    apply_reset();
    vsync_pulse();
    for (int l = 0; l < 70; l++) send_line(160);
    send_pixel(2'd1);
    d = done_count;
    lcd_pixel = 1'b1;
    lcd_color = 2'd2;
    @(posedge clk);
    #2 rst = 1'b0;
    lcd_pixel = 1'b0;
    #1 check_reset_outputs("midreset");
    tick(2);
    rst = 1'b1;
    tick();
    check_output("midreset_done", 32'(done_count - d), 32'd0);
    b = wr_count;
    send_line(10);
    check_output("midreset_wait_writes", 32'(wr_count - b), 32'd0);
    full_frame_check("frame2");

    check_output("bank_violations", 32'(bank_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
